block_stats_collector: RTL and testbench
========================================

Name: block_stats_collector

Overview:
- Streaming producer of the per-block statistics consumed by the block threshold calculator: min, max and sum for each of two score channels, plus the tile count.
- Sits between the tile-score datapath and the threshold calculator. Accepts one tile score pair per valid/ready beat.
- Frames a block with start/last and presents registered results under a valid/ready handshake.

Parameters:
- WIDTH, 8: base width. Scores and statistics are 2*WIDTH bits unsigned.
- MAX_TILES, 1023: hard tile-count limit. Must be no greater than 1023, since the count is 10 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a new block; sampled only in IDLE.
- tile_valid  in  1  tile score pair present.
- tile_ready  out  1  collector can accept a tile.
- tile_last  in  1  final tile of block; qualified by the beat.
- score0  in  2*WIDTH  channel-0 tile score.
- score1  in  2*WIDTH  channel-1 tile score.
- min0, max0, sum0  out  2*WIDTH each  channel-0 statistics.
- min1, max1, sum1  out  2*WIDTH each  channel-1 statistics.
- no_of_tiles  out  10  tiles accepted in block.
- stats_valid  out  1  statistics are final.
- stats_ready  in  1  consumer takes statistics.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE.
  - All statistic outputs and no_of_tiles = 0.
  - stats_valid=0, tile_ready=0, busy=0.
  - Reset overrides everything, including mid-block or mid-handshake; partial statistics are discarded.
- States: IDLE, ACCUM, DONE.
  - IDLE -> ACCUM on start=1. Entering ACCUM clears no_of_tiles and the sums.
  - ACCUM -> DONE on an accepted beat with tile_last=1, or when the accepted beat brings no_of_tiles to MAX_TILES (forced close).
  - DONE -> IDLE on stats_valid && stats_ready.
- Handshake and timing:
  - tile_ready = (state==ACCUM), registered-state derived, no combinational path from tile_valid.
  - Beat = tile_valid && tile_ready.
  - start outside IDLE is ignored. tile_valid outside ACCUM is ignored (not consumed).
- Per accepted beat:
  - First beat of block (no_of_tiles==0): minN=maxN=sumN=scoreN.
  - Later beats: minN=min(minN,scoreN), maxN=max(maxN,scoreN), sumN=sumN+scoreN. Comparisons are unsigned.
  - no_of_tiles increments by 1.
- Results:
  - stats_valid=1 exactly from the cycle after the closing beat until the handshake cycle.
  - Outputs hold stable throughout DONE and remain unchanged in IDLE until the next start.
- Latency:
  - Last beat at edge k -> stats_valid high after edge k.
  - stats_ready high in that cycle -> IDLE after edge k+1.
  - Minimum block period: 1 + N + 1 cycles.
- Width rule: the sum adder is 2*WIDTH+1 bits internally. Overflow handling follows the optional feature.
- No empty blocks are possible, because tile_last is only meaningful on a beat. A block therefore always has no_of_tiles >= 1, keeping the downstream reciprocal defined.

Optional Feature:
- Macro: STATS_SUM_SATURATE_EN.
- Defined:
  - sumN clamps at 2^(2*WIDTH)-1.
  - Extra outputs sat0 and sat1 (1 bit each): sticky per block, cleared on block start, reset to 0.
- Undefined:
  - sumN wraps modulo 2^(2*WIDTH).
  - No sat ports.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, ACCUM=2'd1, DONE=2'd2;
  - the 10-bit tile-count width constant, reused by the threshold calculator's tile-count input;
  - the statistic width function 2*WIDTH.
- One natural sub-module: block_stats_channel. It holds the per-channel min/max/sum registers, the first-beat initialisation and the saturation logic, and is instantiated twice. The top level owns the FSM, the counter and the handshake.

Test Plan:
- start; beats score0 = 5, 2, 9 (last on 9), score1 = 100, 300, 200 -> after the last edge: min0=2, max0=9, sum0=16, min1=100, max1=300, sum1=600, no_of_tiles=3, stats_valid=1.
- Hold stats_ready=0 for 4 cycles, then 1 -> outputs stable and stats_valid held throughout; IDLE and busy=0 after the handshake edge.
- Single beat score0=0xFFFF with last -> min0=max0=sum0=0xFFFF, no_of_tiles=1.
- Beats 0x8000 and 0x9000 on channel 0 -> sum0=0xFFFF with sat0=1 if STATS_SUM_SATURATE_EN is defined, otherwise 0x1000.
- MAX_TILES=4, five valid beats, no last -> DONE after the 4th beat, no_of_tiles=4, 5th beat not consumed (tile_ready=0).
- rst_n=0 for one edge after 2 beats -> all outputs 0, IDLE. A new start followed by a single beat of 7 with last gives min0=max0=sum0=7.

Source files
------------

// File: rtl/block_stats_collector_pkg.sv
// Shared definitions for the block statistics collector and its consumers.
//   state_e  : collector FSM encoding (IDLE / ACCUM / DONE)
//   CNT_W    : tile-count width, also used by the threshold calculator's
//              tile-count input
//   stat_w() : statistic width for a given base width (2*WIDTH)
package block_stats_collector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int CNT_W = 10;

  function automatic int stat_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/block_stats_channel.sv
// Per-channel min/max/sum accumulator for one score channel.
// Optional build macro: STATS_SUM_SATURATE_EN (sum clamps, sticky sat flag).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clr                 block start: clears sum (and sat)
//   beat                accepted tile this cycle
//   first               beat is the first of the block (load, not combine)
//   score               channel score for this beat
//   stat_min/max/sum    running statistics, held between beats/blocks
//   sat                 (macro only) sum clamped at least once this block
module block_stats_channel
  import block_stats_collector_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SW    = stat_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          beat,
  input  logic          first,
  input  logic [SW-1:0] score,
  output logic [SW-1:0] stat_min,
  output logic [SW-1:0] stat_max,
  output logic [SW-1:0] stat_sum
`ifdef STATS_SUM_SATURATE_EN
  ,
  output logic          sat
`endif
);

  logic [SW-1:0] sum_nxt;

`ifdef STATS_SUM_SATURATE_EN
  // One extra bit catches the carry; any carry clamps to all-ones.
  logic [SW:0] sum_ext;
  assign sum_ext = {1'b0, stat_sum} + {1'b0, score};
  assign sum_nxt = sum_ext[SW] ? {SW{1'b1}} : sum_ext[SW-1:0];
`else
  // Wrapping sum: the carry out of the adder is simply dropped.
  assign sum_nxt = stat_sum + score;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_min <= '0;
      stat_max <= '0;
      stat_sum <= '0;
`ifdef STATS_SUM_SATURATE_EN
      sat      <= 1'b0;
`endif
    end else if (clr) begin
      // min/max are left alone: the first beat overwrites them anyway.
      stat_sum <= '0;
`ifdef STATS_SUM_SATURATE_EN
      sat      <= 1'b0;
`endif
    end else if (beat) begin
      if (first) begin
        stat_min <= score;
        stat_max <= score;
        stat_sum <= score;
      end else begin
        if (score < stat_min) stat_min <= score;
        if (score > stat_max) stat_max <= score;
        stat_sum <= sum_nxt;
`ifdef STATS_SUM_SATURATE_EN
        if (sum_ext[SW]) sat <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/block_stats_collector.sv
// Streaming per-block statistics collector: min/max/sum for two score
// channels plus tile count, framed by start/tile_last, results presented
// under a stats_valid/stats_ready handshake.
// Optional build macro: STATS_SUM_SATURATE_EN (adds sat0/sat1, clamped sums).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   start                           begin a block (honoured in IDLE only)
//   tile_valid/tile_ready/tile_last tile stream handshake and framing
//   score0, score1                  channel scores (2*WIDTH, unsigned)
//   min0/max0/sum0, min1/max1/sum1  channel statistics
//   no_of_tiles                     tiles accepted in the block
//   stats_valid/stats_ready         result handshake
//   busy                            collector not in IDLE
//   sat0, sat1                      (macro only) sticky per-block clamp flags
// MAX_TILES must be in 1..1023 (10-bit count).
module block_stats_collector
  import block_stats_collector_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_TILES = 1023,
  localparam int SW        = stat_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             tile_valid,
  output logic             tile_ready,
  input  logic             tile_last,
  input  logic [SW-1:0]    score0,
  input  logic [SW-1:0]    score1,
  output logic [SW-1:0]    min0,
  output logic [SW-1:0]    max0,
  output logic [SW-1:0]    sum0,
  output logic [SW-1:0]    min1,
  output logic [SW-1:0]    max1,
  output logic [SW-1:0]    sum1,
  output logic [CNT_W-1:0] no_of_tiles,
  output logic             stats_valid,
  input  logic             stats_ready,
  output logic             busy
`ifdef STATS_SUM_SATURATE_EN
  ,
  output logic             sat0,
  output logic             sat1
`endif
);

  localparam int               NUM_CH  = 2;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TILES);

  state_e                      state;
  logic                        beat, clr, first, close;
  logic [CNT_W-1:0]            cnt_inc;
  logic [NUM_CH-1:0][SW-1:0]   score_v, min_v, max_v, sum_v;

  // tile_ready is a flop set only in ACCUM, so beat never loops back
  // combinationally from tile_valid to tile_ready.
  assign beat    = tile_valid && tile_ready;
  assign clr     = (state == IDLE) && start;
  assign first   = (no_of_tiles == '0);
  assign cnt_inc = no_of_tiles + CNT_W'(1);
  assign close   = tile_last || (cnt_inc == MAX_CNT);

  assign score_v = {score1, score0};

`ifdef STATS_SUM_SATURATE_EN
  logic [NUM_CH-1:0] sat_v;
  assign sat0 = sat_v[0];
  assign sat1 = sat_v[1];
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    block_stats_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .beat     (beat),
      .first    (first),
      .score    (score_v[c]),
      .stat_min (min_v[c]),
      .stat_max (max_v[c]),
      .stat_sum (sum_v[c])
`ifdef STATS_SUM_SATURATE_EN
      ,
      .sat      (sat_v[c])
`endif
    );
  end

  assign min0 = min_v[0];
  assign max0 = max_v[0];
  assign sum0 = sum_v[0];
  assign min1 = min_v[1];
  assign max1 = max_v[1];
  assign sum1 = sum_v[1];

  // FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      no_of_tiles <= '0;
      tile_ready  <= 1'b0;
      stats_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ACCUM;
            no_of_tiles <= '0;
            tile_ready  <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat) begin
            no_of_tiles <= cnt_inc;
            if (close) begin
              state       <= DONE;
              tile_ready  <= 1'b0;
              stats_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (stats_ready) begin
            state       <= IDLE;
            stats_valid <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          tile_ready  <= 1'b0;
          stats_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_stats_collector.sv
// Self-checking bench for block_stats_collector (MAX_TILES=4 so forced
// close is exercised by both directed and random blocks).
module tb_block_stats_collector;

  localparam int WIDTH = 8;
  localparam int SW    = 2 * WIDTH;
  localparam int MAXT  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, tile_valid, tile_last, stats_ready;
  logic          tile_ready, stats_valid, busy;
  logic [SW-1:0] score0, score1;
  logic [SW-1:0] min0, max0, sum0, min1, max1, sum1;
  logic [9:0]    no_of_tiles;
`ifdef STATS_SUM_SATURATE_EN
  logic          sat0, sat1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  block_stats_collector #(.WIDTH(WIDTH), .MAX_TILES(MAXT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .tile_valid  (tile_valid),
    .tile_ready  (tile_ready),
    .tile_last   (tile_last),
    .score0      (score0),
    .score1      (score1),
    .min0        (min0),
    .max0        (max0),
    .sum0        (sum0),
    .min1        (min1),
    .max1        (max1),
    .sum1        (sum1),
    .no_of_tiles (no_of_tiles),
    .stats_valid (stats_valid),
    .stats_ready (stats_ready),
    .busy        (busy)
`ifdef STATS_SUM_SATURATE_EN
    ,
    .sat0        (sat0),
    .sat1        (sat1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stimulus for the next block: scores per beat and the index carrying
  // tile_last (-1 = never asserted, relies on the MAXT forced close).
  logic [SW-1:0] q0[$], q1[$];
  int            last_idx;

  // Expected results, computed from the block's accepted scores.
  int unsigned e_min0, e_max0, e_sum0, e_min1, e_max1, e_sum1, e_cnt;
  bit          e_sat0, e_sat1;

  function automatic void model(input logic [SW-1:0] a0[$], input logic [SW-1:0] a1[$]);
    int unsigned lim = (1 << SW) - 1;
    e_cnt = a0.size();
    e_min0 = lim; e_max0 = 0; e_sum0 = 0; e_sat0 = 0;
    e_min1 = lim; e_max1 = 0; e_sum1 = 0; e_sat1 = 0;
    foreach (a0[i]) begin
      if (a0[i] < e_min0) e_min0 = a0[i];
      if (a0[i] > e_max0) e_max0 = a0[i];
      if (a1[i] < e_min1) e_min1 = a1[i];
      if (a1[i] > e_max1) e_max1 = a1[i];
      e_sum0 += a0[i];
      e_sum1 += a1[i];
`ifdef STATS_SUM_SATURATE_EN
      if (e_sum0 > lim) begin e_sum0 = lim; e_sat0 = 1; end
      if (e_sum1 > lim) begin e_sum1 = lim; e_sat1 = 1; end
`else
      e_sum0 = e_sum0 % (lim + 1);
      e_sum1 = e_sum1 % (lim + 1);
`endif
    end
  endfunction

  task automatic chk_stats(input string tag);
    chk({tag, "_min0"}, 32'(min0), e_min0);
    chk({tag, "_max0"}, 32'(max0), e_max0);
    chk({tag, "_sum0"}, 32'(sum0), e_sum0);
    chk({tag, "_min1"}, 32'(min1), e_min1);
    chk({tag, "_max1"}, 32'(max1), e_max1);
    chk({tag, "_sum1"}, 32'(sum1), e_sum1);
    chk({tag, "_cnt"},  32'(no_of_tiles), e_cnt);
`ifdef STATS_SUM_SATURATE_EN
    chk({tag, "_sat0"}, 32'(sat0), 32'(e_sat0));
    chk({tag, "_sat1"}, 32'(sat1), 32'(e_sat1));
`endif
  endtask

  // Runs one block from IDLE through the result handshake, holding
  // stats_ready low for 'stall' cycles first.
  task automatic run_block(input string tag, input int stall);
    logic [SW-1:0] acc0[$], acc1[$];
    bit open = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_ready_on"}, 32'(tile_ready), 1);
    chk({tag, "_busy_on"},  32'(busy), 1);
    foreach (q0[i]) begin
      tile_valid = 1'b1;
      score0     = q0[i];
      score1     = q1[i];
      tile_last  = (i == last_idx);
      @(posedge clk); #1;
      if (open) begin
        acc0.push_back(q0[i]);
        acc1.push_back(q1[i]);
        if (i == last_idx || acc0.size() == MAXT) open = 0;
      end
      chk({tag, "_valid_beat"}, 32'(stats_valid), 32'(!open));
      chk({tag, "_ready_beat"}, 32'(tile_ready), 32'(open));
    end
    tile_valid = 1'b0;
    tile_last  = 1'b0;
    model(acc0, acc1);
    chk_stats({tag, "_done"});
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk({tag, "_valid_hold"}, 32'(stats_valid), 1);
      chk({tag, "_sum0_hold"},  32'(sum0), e_sum0);
      chk({tag, "_max1_hold"},  32'(max1), e_max1);
    end
    stats_ready = 1'b1;
    @(posedge clk); #1;
    stats_ready = 1'b0;
    chk({tag, "_valid_off"}, 32'(stats_valid), 0);
    chk({tag, "_busy_off"},  32'(busy), 0);
    chk({tag, "_ready_off"}, 32'(tile_ready), 0);
    chk_stats({tag, "_idle"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; tile_valid = 1'b0; tile_last = 1'b0;
    stats_ready = 1'b0; score0 = '0; score1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(stats_valid), 0);
    chk("rst_ready", 32'(tile_ready), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_cnt",   32'(no_of_tiles), 0);
    chk("rst_sum0",  32'(sum0), 0);
    chk("rst_min1",  32'(min1), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tile stream ignored in IDLE.
    tile_valid = 1'b1; tile_last = 1'b1; score0 = 16'h1234;
    @(posedge clk); #1;
    chk("idle_ignore_cnt",  32'(no_of_tiles), 0);
    chk("idle_ignore_busy", 32'(busy), 0);
    tile_valid = 1'b0; tile_last = 1'b0;

    // Basic block with a 4-cycle result stall.
    q0 = '{16'd5, 16'd2, 16'd9}; q1 = '{16'd100, 16'd300, 16'd200}; last_idx = 2;
    run_block("basic", 4);
    chk("basic_sum0_lit", 32'(sum0), 16);
    chk("basic_sum1_lit", 32'(sum1), 600);

    // Single full-scale beat.
    q0 = '{16'hFFFF}; q1 = '{16'h0001}; last_idx = 0;
    run_block("single", 0);

    // Channel-0 sum overflow.
    q0 = '{16'h8000, 16'h9000}; q1 = '{16'd1, 16'd2}; last_idx = 1;
    run_block("ovf", 1);

    // Forced close at MAXT; fifth beat must not be consumed.
    q0 = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    q1 = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd3}; last_idx = -1;
    run_block("force", 2);
    chk("force_cnt_lit", 32'(no_of_tiles), 4);

    // Reset mid-block discards everything.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tile_valid = 1'b1; score0 = 16'd33; score1 = 16'd44;
    repeat (2) @(posedge clk);
    #1;
    tile_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_busy",  32'(busy), 0);
    chk("mrst_ready", 32'(tile_ready), 0);
    chk("mrst_valid", 32'(stats_valid), 0);
    chk("mrst_cnt",   32'(no_of_tiles), 0);
    chk("mrst_sum0",  32'(sum0), 0);
    chk("mrst_max0",  32'(max0), 0);
    q0 = '{16'd7}; q1 = '{16'd9}; last_idx = 0;
    run_block("post_rst", 0);

    // Randomized blocks, including forced closes and overflowing sums.
    for (int b = 0; b < 30; b++) begin
      int len = $urandom_range(1, 6);
      q0 = {}; q1 = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          q0.push_back(16'($urandom)); q1.push_back(16'($urandom));
        end else begin
          q0.push_back(16'($urandom_range(0, 255))); q1.push_back(16'($urandom_range(0, 255)));
        end
      end
      if (len >= MAXT && $urandom_range(0, 2) == 0) last_idx = -1;
      else last_idx = $urandom_range(0, len - 1);
      run_block("rand", $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
